// File: rtl/conv_frame_ctrl.sv
// Frame sequencer for the 3x3 window line buffer: loads one zero-padded frame,
// scans every window base in raster order, tracks filter latency to produce
// result write strobes/addresses, then pulses done.
// Optional: define CONV_FRAME_CTRL_ABORT_EN to add an abort input that returns
// the sequencer to IDLE from any active state without a done pulse.
module conv_frame_ctrl #(
  parameter int unsigned IMG_W    = 256,
  parameter int unsigned IMG_H    = 32,
  parameter int unsigned PIPE_LAT = 3,
  parameter int unsigned AW       = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          buf_wr,
  output logic [AW-1:0] buf_waddr,
  input  logic          hold,
  output logic          buf_rd,
  output logic [AW-1:0] win_base,
  output logic          res_wr,
  output logic [AW-1:0] res_waddr,
  output logic          busy,
  output logic          done
`ifdef CONV_FRAME_CTRL_ABORT_EN
  ,
  input  logic          abort
`endif
);

  localparam int unsigned PAD_W     = IMG_W + 2;
  localparam int unsigned PAD_H     = IMG_H + 2;
  localparam int unsigned LOAD_LAST = PAD_W * PAD_H - 1;
  localparam int unsigned RES_LAST  = IMG_W * IMG_H - 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SCAN  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic [AW-1:0]        load_cnt_q, load_cnt_d;
  logic [AW-1:0]        col_q, col_d;
  logic [AW-1:0]        row_q, row_d;
  logic [AW-1:0]        base_q, base_d;
  logic [AW-1:0]        win_base_q, win_base_d;
  logic                 buf_rd_q, buf_rd_d;
  logic [PIPE_LAT-1:0]  pipe_q, pipe_d;
  logic [AW-1:0]        res_cnt_q, res_cnt_d;
  logic                 in_ready_q, in_ready_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 abort_c;

`ifdef CONV_FRAME_CTRL_ABORT_EN
  assign abort_c = abort;
`else
  assign abort_c = 1'b0;
`endif

  // Next-state, counters and registered-output values
  always_comb begin
    state_d    = state_q;
    load_cnt_d = load_cnt_q;
    col_d      = col_q;
    row_d      = row_q;
    base_d     = base_q;
    win_base_d = win_base_q;
    buf_rd_d   = 1'b0;
    pipe_d     = (pipe_q << 1) | PIPE_LAT'(buf_rd_q);
    res_cnt_d  = res_cnt_q;

    // The result address stays on the last slot once the final result is written
    if (pipe_q[PIPE_LAT-1] && (res_cnt_q != AW'(RES_LAST))) begin
      res_cnt_d = res_cnt_q + AW'(1);
    end

    case (state_q)
      IDLE: begin
        if (start) state_d = LOAD;
      end
      LOAD: begin
        if (in_valid && in_ready_q) begin
          if (load_cnt_q == AW'(LOAD_LAST)) begin
            state_d = SCAN;
          end else begin
            load_cnt_d = load_cnt_q + AW'(1);
          end
        end
      end
      SCAN: begin
        if (!hold) begin
          buf_rd_d   = 1'b1;
          win_base_d = base_q;
          if (col_q == AW'(IMG_W - 1)) begin
            col_d  = '0;
            row_d  = row_q + AW'(1);
            base_d = base_q + AW'(3);
            if (row_q == AW'(IMG_H - 1)) state_d = DRAIN;
          end else begin
            col_d  = col_q + AW'(1);
            base_d = base_q + AW'(1);
          end
        end
      end
      DRAIN: begin
        if (!buf_rd_q && (pipe_q == '0)) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (abort_c && (state_q != IDLE)) state_d = IDLE;

    // Entering or sitting in IDLE wipes all frame bookkeeping
    if (state_d == IDLE) begin
      load_cnt_d = '0;
      col_d      = '0;
      row_d      = '0;
      base_d     = '0;
      win_base_d = '0;
      buf_rd_d   = 1'b0;
      pipe_d     = '0;
      res_cnt_d  = '0;
    end

    in_ready_d = (state_d == LOAD);
    busy_d     = (state_d != IDLE);
    done_d     = (state_d == DONE);
  end

  // State and counter registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      load_cnt_q <= '0;
      col_q      <= '0;
      row_q      <= '0;
      base_q     <= '0;
      win_base_q <= '0;
      buf_rd_q   <= 1'b0;
      pipe_q     <= '0;
      res_cnt_q  <= '0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      load_cnt_q <= load_cnt_d;
      col_q      <= col_d;
      row_q      <= row_d;
      base_q     <= base_d;
      win_base_q <= win_base_d;
      buf_rd_q   <= buf_rd_d;
      pipe_q     <= pipe_d;
      res_cnt_q  <= res_cnt_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign buf_wr    = in_valid & in_ready_q;
  assign buf_waddr = load_cnt_q;
  assign buf_rd    = buf_rd_q;
  assign win_base  = win_base_q;
  assign res_wr    = pipe_q[PIPE_LAT-1];
  assign res_waddr = res_cnt_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_conv_frame_ctrl.sv
// Bench for conv_frame_ctrl on a small 4x2 image: frame-level scenario table,
// randomized frames, and hand-written reset / abort sequences.
module tb_conv_frame_ctrl;

  localparam int unsigned IMG_W    = 4;
  localparam int unsigned IMG_H    = 2;
  localparam int unsigned PIPE_LAT = 3;
  localparam int unsigned AW       = 15;
  localparam int          PAD_W    = IMG_W + 2;
  localparam int          NPIX     = (IMG_W + 2) * (IMG_H + 2);
  localparam int          NRES     = IMG_W * IMG_H;

  logic          clk = 1'b0;
  logic          rst_n, start, in_valid, hold;
  logic          in_ready, buf_wr, buf_rd, res_wr, busy, done;
  logic [AW-1:0] buf_waddr, win_base, res_waddr;
`ifdef CONV_FRAME_CTRL_ABORT_EN
  logic          abort;
`endif

  always #5 clk = ~clk;

  conv_frame_ctrl #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .PIPE_LAT(PIPE_LAT), .AW(AW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .buf_wr(buf_wr), .buf_waddr(buf_waddr),
    .hold(hold), .buf_rd(buf_rd), .win_base(win_base),
    .res_wr(res_wr), .res_waddr(res_waddr), .busy(busy), .done(done)
`ifdef CONV_FRAME_CTRL_ABORT_EN
    , .abort(abort)
`endif
  );

  typedef struct {
    int cyc;
    int val;
  } ev_t;

  // Scenario record: stimulus modes plus the frame-level outcome they must give
  typedef struct {
    int vmode;       // 0 continuous in_valid, 1 every other cycle, 2 random
    int hmode;       // 0 no hold, 1 two-cycle hold after 2nd read, 2 random
    bit start_scan;  // pulse start while scanning
    int exp_reads;
    int exp_res;
    int exp_done;
    int exp_span;    // last read cycle - first read cycle, -1 = not checked
    int exp_rd_lat;  // first read cycle - last write cycle, -1 = not checked
  } frame_vec_t;

  ev_t wr_q[$], rd_q[$], res_q[$];
  int  done_q[$];
  bit  hold_h [0:8191];
  bit  busy_h [0:8191];
  int  cyc = 0;
  int  n_vec = 0;
  int  n_err = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Sample outputs mid-cycle, then advance to just after the next rising edge
  task automatic tick();
    @(negedge clk);
    hold_h[cyc & 8191] = hold;
    busy_h[cyc & 8191] = busy;
    if (buf_wr) wr_q.push_back('{cyc, int'(buf_waddr)});
    if (buf_rd) rd_q.push_back('{cyc, int'(win_base)});
    if (res_wr) res_q.push_back('{cyc, int'(res_waddr)});
    if (done)   done_q.push_back(cyc);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clear_log();
    wr_q.delete(); rd_q.delete(); res_q.delete(); done_q.delete();
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_buf_wr"},   buf_wr,   0);
    chk({tag, "_buf_rd"},   buf_rd,   0);
    chk({tag, "_res_wr"},   res_wr,   0);
    chk({tag, "_busy"},     busy,     0);
    chk({tag, "_done"},     done,     0);
    chk({tag, "_waddr"},    buf_waddr, 0);
    chk({tag, "_win_base"}, win_base, 0);
    chk({tag, "_res_waddr"}, res_waddr, 0);
  endtask

  // Compare a logged frame against the expected raster of writes, windows and results
  task automatic check_frame(input string tag, input frame_vec_t v);
    int n;
    chk({tag, "_wr_count"}, wr_q.size(), NPIX);
    n = (wr_q.size() < NPIX) ? wr_q.size() : NPIX;
    for (int i = 0; i < n; i++) chk({tag, "_wr_addr"}, wr_q[i].val, i);

    chk({tag, "_rd_count"}, rd_q.size(), v.exp_reads);
    n = (rd_q.size() < NRES) ? rd_q.size() : NRES;
    for (int i = 0; i < n; i++) begin
      chk({tag, "_win_base"}, rd_q[i].val, (i / IMG_W) * PAD_W + (i % IMG_W));
      chk({tag, "_rd_under_hold"}, hold_h[(rd_q[i].cyc - 1) & 8191], 0);
    end

    chk({tag, "_res_count"}, res_q.size(), v.exp_res);
    n = (res_q.size() < rd_q.size()) ? res_q.size() : rd_q.size();
    for (int i = 0; i < n; i++) begin
      chk({tag, "_res_addr"}, res_q[i].val, i);
      chk({tag, "_res_latency"}, res_q[i].cyc - rd_q[i].cyc, PIPE_LAT);
    end

    if (wr_q.size() > 0 && rd_q.size() > 0) begin
      chk({tag, "_scan_after_load"}, rd_q[0].cyc > wr_q[wr_q.size()-1].cyc, 1);
      if (v.exp_rd_lat >= 0)
        chk({tag, "_rd_start"}, rd_q[0].cyc - wr_q[wr_q.size()-1].cyc, v.exp_rd_lat);
      if (v.exp_span >= 0)
        chk({tag, "_scan_span"}, rd_q[rd_q.size()-1].cyc - rd_q[0].cyc, v.exp_span);
    end

    chk({tag, "_done_count"}, done_q.size(), v.exp_done);
    if (done_q.size() > 0 && res_q.size() > 0) begin
      chk({tag, "_done_after_res"}, done_q[0] > res_q[res_q.size()-1].cyc, 1);
      chk({tag, "_busy_at_done"}, busy_h[done_q[0] & 8191], 1);
      chk({tag, "_busy_after_done"}, busy_h[(done_q[0] + 1) & 8191], 0);
    end
  endtask

  task automatic run_frame(input string tag, input frame_vec_t v);
    int hold_left = 0;
    bit hold_used = 0;
    int after_done = -1;
    clear_log();
    start = 1'b1; in_valid = 1'b0; hold = 1'b0;
    tick();
    start = 1'b0;
    for (int k = 0; k < 600 && after_done < 2; k++) begin
      case (v.vmode)
        0:       in_valid = 1'b1;
        1:       in_valid = k[0];
        default: in_valid = 1'($urandom % 2);
      endcase
      case (v.hmode)
        0: hold = 1'b0;
        1: begin
          if (rd_q.size() == 2 && !hold_used) begin
            hold_left = 2;
            hold_used = 1'b1;
          end
          hold = (hold_left > 0);
          if (hold_left > 0) hold_left--;
        end
        default: hold = ($urandom % 3) == 0;
      endcase
      start = v.start_scan && (rd_q.size() == 3);
      tick();
      if (done_q.size() > 0) after_done++;
    end
    start = 1'b0; in_valid = 1'b0; hold = 1'b0;
    chk({tag, "_finished"}, after_done >= 0, 1);
    check_frame(tag, v);
  endtask

  frame_vec_t tbl [6];

  initial begin
    tbl[0] = '{0, 0, 1'b0, NRES, NRES, 1, NRES - 1,     2};
    tbl[1] = '{1, 0, 1'b0, NRES, NRES, 1, NRES - 1,     2};
    tbl[2] = '{0, 1, 1'b0, NRES, NRES, 1, NRES - 1 + 2, 2};
    tbl[3] = '{0, 0, 1'b1, NRES, NRES, 1, NRES - 1,     2};
    tbl[4] = '{2, 2, 1'b0, NRES, NRES, 1, -1,          -1};
    tbl[5] = '{2, 2, 1'b1, NRES, NRES, 1, -1,          -1};

    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; hold = 1'b0;
`ifdef CONV_FRAME_CTRL_ABORT_EN
    abort = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk_idle("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // in_valid while idle must be refused
    in_valid = 1'b1;
    tick(); tick();
    @(negedge clk);
    chk_idle("idle_valid");
    @(posedge clk); #1;
    in_valid = 1'b0;

    // Scenario table, back to back so each start lands right after the previous done
    for (int i = 0; i < 6; i++) run_frame($sformatf("tbl%0d", i), tbl[i]);

    // Reset in the middle of the scan
    clear_log();
    start = 1'b1; tick(); start = 1'b0;
    in_valid = 1'b1;
    for (int k = 0; k < 200 && rd_q.size() < 3; k++) tick();
    chk("rstmid_reached_scan", rd_q.size() >= 3, 1);
    rst_n = 1'b0;
    tick();
    @(negedge clk);
    chk_idle("rstmid");
    @(posedge clk); #1;
    rst_n = 1'b1; in_valid = 1'b0;
    tick(); tick();
    chk("rstmid_no_done", done_q.size(), 0);
    run_frame("after_rst", tbl[0]);

    // Randomized frames
    for (int i = 0; i < 4; i++) run_frame($sformatf("rand%0d", i), tbl[4]);

`ifdef CONV_FRAME_CTRL_ABORT_EN
    begin
      int n_res;
      int abort_cyc;
      clear_log();
      start = 1'b1; tick(); start = 1'b0;
      in_valid = 1'b1;
      for (int k = 0; k < 200 && rd_q.size() < NRES; k++) tick();
      chk("abort_reached_drain", rd_q.size(), NRES);
      in_valid = 1'b0;
      abort = 1'b1;
      abort_cyc = cyc;
      tick();
      abort = 1'b0;
      n_res = res_q.size();
      repeat (5) tick();
      chk("abort_res_stops", res_q.size(), n_res);
      chk("abort_cut_short", n_res < NRES, 1);
      chk("abort_no_done", done_q.size(), 0);
      chk("abort_busy", busy_h[(abort_cyc + 1) & 8191], 0);
      run_frame("after_abort", tbl[0]);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
